// File: rtl/mem_stage.sv
// Memory-access stage: ALU results pass through in one cycle, and loads/stores run as byte cycles on an 8-bit RAM port.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word accesses are rejected and flagged on misalign_o.
module mem_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            memop_i,
    input  logic [31:0]           sdata_i,
    input  logic [7:0]            mem_din_i,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    output logic                  stall_req_o,
    output logic                  valid_o,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_o
`endif
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE
    } state_e;

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [23:0] loadBytes_q;
    logic        valid_q;
    logic        wreg_q;
    logic [4:0]  wd_q;
    logic [31:0] wdata_q;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_q;
`endif

    logic        opLoad;
    logic        opStore;
    logic [1:0]  lastIdx;
    logic        misalign;
    logic        issue;
    logic [1:0]  offset;
    logic [31:0] loadWord;

    // lastIdx is the index of the final byte (N-1) of the current op.
    always_comb begin
        opLoad  = 1'b0;
        opStore = 1'b0;
        lastIdx = 2'd0;
        case (memop_i)
            OP_LB, OP_LBU: opLoad = 1'b1;
            OP_LH, OP_LHU: begin opLoad = 1'b1; lastIdx = 2'd1; end
            OP_LW:         begin opLoad = 1'b1; lastIdx = 2'd3; end
            OP_SB:         opStore = 1'b1;
            OP_SH:         begin opStore = 1'b1; lastIdx = 2'd1; end
            OP_SW:         begin opStore = 1'b1; lastIdx = 2'd3; end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = (opLoad || opStore) &&
                      ((lastIdx == 2'd1 && wdata_i[0]) ||
                       (lastIdx == 2'd3 && wdata_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Byte 0 is issued straight from IDLE so that back-to-back instructions need no bubble.
    // In LOAD, cnt_q is the byte being captured, so the next address is one ahead of it.
    always_comb begin
        issue       = 1'b0;
        offset      = 2'd0;
        mem_wr_o    = 1'b0;
        mem_dout_o  = 8'h00;
        stall_req_o = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (valid_i && (opLoad || opStore) && !misalign) begin
                        issue       = 1'b1;
                        mem_wr_o    = opStore;
                        mem_dout_o  = opStore ? sdata_i[7:0] : 8'h00;
                        stall_req_o = opLoad || (lastIdx != 2'd0);
                    end
                end
                LOAD: begin
                    if (cnt_q != lastIdx) begin
                        issue       = 1'b1;
                        offset      = cnt_q + 2'd1;
                        stall_req_o = 1'b1;
                    end
                end
                STORE: begin
                    issue       = 1'b1;
                    offset      = cnt_q;
                    mem_wr_o    = 1'b1;
                    mem_dout_o  = sdata_i[{cnt_q, 3'b000} +: 8];
                    stall_req_o = (cnt_q != lastIdx);
                end
                default: ;
            endcase
        end
        mem_a_o = issue ? (wdata_i[ADDR_WIDTH-1:0] + ADDR_WIDTH'(offset)) : '0;
    end

    // The final byte is taken directly from the RAM port rather than from the buffer.
    always_comb begin
        loadWord = {mem_din_i, loadBytes_q};
        case (memop_i)
            OP_LB:   loadWord = {{24{mem_din_i[7]}}, mem_din_i};
            OP_LBU:  loadWord = {24'h000000, mem_din_i};
            OP_LH:   loadWord = {{16{mem_din_i[7]}}, mem_din_i, loadBytes_q[7:0]};
            OP_LHU:  loadWord = {16'h0000, mem_din_i, loadBytes_q[7:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            loadBytes_q <= 24'h000000;
            valid_q     <= 1'b0;
            wreg_q      <= 1'b0;
            wd_q        <= 5'd0;
            wdata_q     <= 32'h00000000;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        if (misalign) begin
                            valid_q <= 1'b1;
                            wd_q    <= wd_i;
`ifdef MEM_MISALIGN_CHECK_EN
                            misalign_q <= 1'b1;
`endif
                        end else if (opLoad) begin
                            state_q <= LOAD;
                            cnt_q   <= 2'd0;
                        end else if (opStore && lastIdx != 2'd0) begin
                            state_q <= STORE;
                            cnt_q   <= 2'd1;
                        end else begin
                            valid_q <= 1'b1;
                            wd_q    <= wd_i;
                            wreg_q  <= wreg_i && !opStore;
                            if (!opStore) begin
                                wdata_q <= wdata_i;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (cnt_q == lastIdx) begin
                        valid_q <= 1'b1;
                        wd_q    <= wd_i;
                        wreg_q  <= wreg_i;
                        wdata_q <= loadWord;
                        state_q <= IDLE;
                        cnt_q   <= 2'd0;
                    end else begin
                        case (cnt_q)
                            2'd0:    loadBytes_q[7:0]   <= mem_din_i;
                            2'd1:    loadBytes_q[15:8]  <= mem_din_i;
                            default: loadBytes_q[23:16] <= mem_din_i;
                        endcase
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                STORE: begin
                    if (cnt_q == lastIdx) begin
                        valid_q <= 1'b1;
                        wd_q    <= wd_i;
                        state_q <= IDLE;
                        cnt_q   <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o = valid_q;
    assign wreg_o  = wreg_q;
    assign wd_o    = wd_q;
    assign wdata_o = wdata_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_o = misalign_q;
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage (via the ex/mem pipeline register); feeds the mem/wb register.
- ALU results pass through with one cycle of latency.
- Loads and stores are serialised into byte transfers on an 8-bit synchronous RAM port.
- Asserts a stall request to freeze upstream stages while a multi-byte access is in flight.

Parameters:
ADDR_WIDTH, 32, width of mem_a_o; low ADDR_WIDTH bits of the effective address are used.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
valid_i  input  1  instruction present from ex/mem register
wd_i  input  5  destination register address
wreg_i  input  1  instruction writes a register
wdata_i  input  32  ALU result; effective address for memory ops
memop_i  input  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; others treated as NONE
sdata_i  input  32  store data
mem_din_i  input  8  RAM read data, valid one cycle after address
mem_a_o  output  ADDR_WIDTH  RAM byte address
mem_dout_o  output  8  RAM write data
mem_wr_o  output  1  1 write, 0 read
stall_req_o  output  1  upstream must hold its inputs stable while high
valid_o  output  1  one-cycle pulse per completed instruction
wd_o  output  5  destination register to writeback
wreg_o  output  1  write enable to writeback
wdata_o  output  32  writeback data

Behaviour:
- States: IDLE, LOAD, STORE. Byte counter cnt, 0..3. N = bytes per op: 1 for B, 2 for H, 4 for W.
- Reset: state IDLE, cnt 0. valid_o, wreg_o, wd_o, wdata_o, mem_a_o, mem_dout_o, mem_wr_o all 0. stall_req_o 0.
- Reset mid-access aborts the access. No completion pulse is produced.
- In IDLE with no access issued: mem_a_o=0, mem_wr_o=0, mem_dout_o=0.
- In every cycle without a completion: valid_o=0 and wreg_o=0. wd_o and wdata_o hold their previous values.
- IDLE, valid_i=0: stay in IDLE.
- IDLE, valid_i=1, NONE op:
  - Next cycle: valid_o=1; wd_o, wreg_o, wdata_o copied from the inputs.
  - stall_req_o=0.
- Load, cycle k = 0..N-1 relative to acceptance:
  - mem_a_o = wdata_i + k (mod 2^ADDR_WIDTH), mem_wr_o=0.
  - Byte k is captured from mem_din_i at the end of cycle k+1.
- Load stall and completion:
  - stall_req_o is high in cycles 0..N-1 and low in cycle N.
  - At the end of cycle N the last byte is taken directly from mem_din_i. Assembly is little-endian (byte 0 = bits 7:0).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The result is registered to wdata_o with valid_o=1; state returns to IDLE.
  - Total latency N+1 cycles. LB: stall_req_o high in cycle 0 only.
- Store, cycle k = 0..N-1:
  - mem_a_o = wdata_i + k, mem_dout_o = sdata_i[8k+7:8k], mem_wr_o=1.
  - stall_req_o is high in cycles 0..N-2 (SB never stalls).
  - Completes at the end of cycle N-1: valid_o=1, wreg_o=0, wd_o=wd_i.
- Stores force wreg_o=0 regardless of wreg_i. Loads use wreg_i as given.
- stall_req_o is combinational from state and the current inputs. Upstream advances at the first edge where it is low.
- The next instruction is accepted in the cycle after completion, so back-to-back instructions have no bubble.
- Address wrap-around across 2^ADDR_WIDTH is permitted.
- Misaligned accesses are executed byte-wise like aligned ones.
- Inputs changing while stall_req_o is high is an upstream protocol violation. Behaviour is undefined.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A halfword access with addr[0]!=0, or a word access with addr[1:0]!=0, issues no RAM cycle and asserts no stall.
  - It completes the next cycle with valid_o=1, wreg_o=0, misalign_o=1 for that cycle only.
- Not defined: the port is absent; misaligned accesses are performed byte-wise.

Test Plan:
- Reset, then NONE op wd_i=5, wreg_i=1, wdata_i=0x1234 -> next cycle valid_o=1, wd_o=5, wreg_o=1, wdata_o=0x1234, stall_req_o never high.
- LW addr 0x100, RAM bytes 0x78,0x56,0x34,0x12 -> mem_a_o 0x100..0x103 in cycles 0..3, stall_req_o high 4 cycles, wdata_o=0x12345678 in cycle 5.
- LB addr 0x20, byte 0x80 -> wdata_o=0xFFFFFF80; LBU same -> 0x00000080; LH bytes 0x34,0x92 -> 0xFFFF9234.
- SW addr 0x40, sdata 0xAABBCCDD -> writes DD,CC,BB,AA to 0x40..0x43 with mem_wr_o=1, stall_req_o high 3 cycles, then valid_o=1 with wreg_o=0.
- LW to addr 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Assert rst in cycle 2 of a second LW -> next cycle IDLE, all outputs 0, no valid_o pulse.
- With MEM_MISALIGN_CHECK_EN: LW addr 0x102 -> no mem_wr_o/mem_a_o activity, next cycle valid_o=1, misalign_o=1, wreg_o=0.
